post_monitor: RTL and testbench
===============================

POST_MONITOR -- requirements
Module: post_monitor

Interface
REQ-001 The block SHALL have parameter GLITCH_POST, default 8'd6, meaning the POST edge count at which the glitch request opens.
REQ-002 The block SHALL have parameter SUCCESS_POST, default 8'd8, meaning the POST edge count that marks a successful glitch.
REQ-003 The block SHALL have parameter CHECK_TIMEOUT, default 24'd9600000, meaning the maximum ticks allowed in ARMED or CHECK (100 ms at 96 MHz).
REQ-004 The block SHALL have parameter RESET_TICKS, default 16'd9600, meaning the reset_req pulse length in ticks.
REQ-005 The block SHALL have parameter MAX_ATTEMPTS, default 4'd15, meaning the failure limit used only when ATTEMPT_LIMIT_EN is defined.
REQ-006 The block SHALL have port clk_96m, input, 1 bit: the 96 MHz clock; one rising edge is one tick.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port post_in, input, 1 bit: the asynchronous POST bit, which toggles once per POST code change.
REQ-009 The block SHALL have port glitch, output, 1 bit: the glitch request to the glitcher, high while the glitch window is open.
REQ-010 The block SHALL have port reset_req, output, 1 bit: when high, the console reset is requested after a failed attempt.
REQ-011 The block SHALL have port success, output, 1 bit: latched high once the boot has passed SUCCESS_POST.
REQ-012 The block SHALL have port halted, output, 1 bit: high when the attempt limit is exhausted.
REQ-013 The block SHALL have port attempts, output, 4 bits: the failed-attempt count.
REQ-014 The block SHALL have port post_cnt, output, 8 bits: the current POST edge count.

Function
REQ-015 The block SHALL synchronise post_in through two flops, then register it once more and detect edges by XOR, so post_edge is a one-tick pulse 3 ticks after any post_in transition.
REQ-016 post_cnt SHALL increment by one on each post_edge, saturate at 8'hFF, and never wrap.
REQ-017 The FSM SHALL have states IDLE, COUNT, ARMED, CHECK, FAIL_RESET, DONE and HALT.
REQ-018 In IDLE, the first post_edge SHALL set post_cnt to 1 and move the FSM to COUNT.
REQ-019 In COUNT, the post_edge that makes post_cnt equal GLITCH_POST SHALL move the FSM to ARMED, with glitch registered high on the following tick.
REQ-020 glitch SHALL be high only in ARMED; the block SHALL clear the timeout timer on entry to ARMED, CHECK and FAIL_RESET.
REQ-021 In ARMED, the next post_edge SHALL drop glitch on the following tick and move the FSM to CHECK.
REQ-022 In ARMED or CHECK, the timer reaching CHECK_TIMEOUT-1 without a qualifying edge SHALL move the FSM to FAIL_RESET.
REQ-023 In CHECK, post_cnt reaching SUCCESS_POST SHALL move the FSM to DONE.
REQ-024 If a qualifying post_edge and the timeout occur in the same tick, the edge SHALL win.
REQ-025 FAIL_RESET SHALL hold reset_req high for exactly RESET_TICKS ticks, increment attempts (saturating at 4'hF), clear post_cnt on entry, and ignore post_edge throughout.
REQ-026 On exit from FAIL_RESET, the FSM SHALL return to IDLE with reset_req low.
REQ-027 DONE SHALL be terminal until rst: success=1, glitch=0, reset_req=0, and post_cnt keeps counting.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from post_in to any output.

Reset
REQ-029 When rst is high on a clk_96m edge, the FSM SHALL go to IDLE and all of the following SHALL clear: glitch=0, reset_req=0, success=0, halted=0, attempts=0, post_cnt=0, timer=0, and the sync flops.
REQ-030 rst SHALL override every state, including mid-FAIL_RESET, where reset_req drops on the next tick.

Configuration
REQ-031 With ATTEMPT_LIMIT_EN defined, a FAIL_RESET exit that leaves attempts equal to MAX_ATTEMPTS SHALL enter HALT: halted=1, all other outputs frozen, reset_req=0, exit only by rst.
REQ-032 Without ATTEMPT_LIMIT_EN, the HALT state SHALL not exist, halted SHALL be tied 0, and retries SHALL be unlimited.

Verification
REQ-033 The bench SHALL toggle post_in 6 times, 1 us apart, and check that glitch rises 4 ticks after the 6th toggle and that post_cnt=6.
REQ-034 The bench SHALL toggle post_in a 7th and 8th time inside the timeout and check that glitch falls 4 ticks after toggle 7, that success=1 after toggle 8, and that reset_req is never asserted.
REQ-035 The bench SHALL give 6 toggles and then no further toggle, and check that reset_req goes high for exactly 9600 ticks after 9600000 ticks in ARMED, that attempts=1, and that the FSM then returns to IDLE.
REQ-036 The bench SHALL toggle post_in during FAIL_RESET and check that post_cnt stays 0 and reset_req width is unchanged.
REQ-037 The bench SHALL, with ATTEMPT_LIMIT_EN and MAX_ATTEMPTS=2, force 2 failures and check that halted=1, reset_req=0, and no glitch occurs on further toggles.
REQ-038 The bench SHALL assert rst during reset_req=1 and check that all outputs are 0 on the next tick.

Source files
------------

// File: rtl/post_monitor.sv
// post_monitor
//   Counts POST code changes on a console and drives a glitch request
//   during a window of the boot sequence. If the boot does not advance
//   in time, the block requests a console reset and counts the failure.
//
//   Ports:
//     clk_96m   - 96 MHz clock; one rising edge is one tick
//     rst       - synchronous, active-high reset
//     post_in   - asynchronous POST bit; toggles once per POST code change
//     glitch    - glitch request; high only while the window is open (ARMED)
//     reset_req - console reset request after a failed attempt
//     success   - latched once the boot has reached SUCCESS_POST
//     halted    - attempt limit exhausted (only with ATTEMPT_LIMIT_EN)
//     attempts  - failed-attempt count, saturating at 4'hF
//     post_cnt  - POST edge count, saturating at 8'hFF
//
//   Optional build macro:
//     ATTEMPT_LIMIT_EN - adds a HALT state that is entered once the number
//                        of failed attempts reaches MAX_ATTEMPTS. When not
//                        defined, retries are unlimited and halted is 0.
module post_monitor #(
  parameter logic [7:0]  GLITCH_POST   = 8'd6,
  parameter logic [7:0]  SUCCESS_POST  = 8'd8,
  parameter logic [23:0] CHECK_TIMEOUT = 24'd9600000,
  parameter logic [15:0] RESET_TICKS   = 16'd9600,
  parameter logic [3:0]  MAX_ATTEMPTS  = 4'd15
) (
  input  logic       clk_96m,
  input  logic       rst,
  input  logic       post_in,
  output logic       glitch,
  output logic       reset_req,
  output logic       success,
  output logic       halted,
  output logic [3:0] attempts,
  output logic [7:0] post_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    ARMED,
    CHECK,
    FAIL_RESET,
    DONE
`ifdef ATTEMPT_LIMIT_EN
    , HALT
`endif
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic        post_edge;
  logic [23:0] timer;
  logic [7:0]  cnt_next;
  logic        timeout_hit;
  logic        reset_done;
  logic        check_qual;

  // Two-flop synchroniser, one more stage for edge detection, and a
  // registered edge pulse so post_edge lands 3 ticks after a transition.
  always_ff @(posedge clk_96m) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      post_edge <= 1'b0;
    end else begin
      sync1     <= post_in;
      sync2     <= sync1;
      sync3     <= sync2;
      post_edge <= sync2 ^ sync3;
    end
  end

  always_comb begin
    cnt_next    = (post_cnt == 8'hFF) ? post_cnt : post_cnt + 8'd1;
    timeout_hit = (timer == CHECK_TIMEOUT - 24'd1);
    reset_done  = (timer == {8'd0, RESET_TICKS} - 24'd1);
    // The level term covers SUCCESS_POST already reached on entry to CHECK.
    check_qual  = (post_edge && (cnt_next >= SUCCESS_POST)) ||
                  (post_cnt >= SUCCESS_POST);
  end

  always_ff @(posedge clk_96m) begin
    if (rst) begin
      state     <= IDLE;
      glitch    <= 1'b0;
      reset_req <= 1'b0;
      success   <= 1'b0;
      attempts  <= '0;
      post_cnt  <= '0;
      timer     <= '0;
`ifdef ATTEMPT_LIMIT_EN
      halted    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (post_edge) begin
            post_cnt <= 8'd1;
            state    <= COUNT;
          end
        end

        COUNT: begin
          if (post_edge) begin
            post_cnt <= cnt_next;
            if (cnt_next == GLITCH_POST) begin
              state  <= ARMED;
              glitch <= 1'b1;
              timer  <= '0;
            end
          end
        end

        // An edge on the timeout tick wins over the timeout.
        ARMED: begin
          if (post_edge) begin
            post_cnt <= cnt_next;
            glitch   <= 1'b0;
            timer    <= '0;
            state    <= CHECK;
          end else if (timeout_hit) begin
            state     <= FAIL_RESET;
            glitch    <= 1'b0;
            reset_req <= 1'b1;
            post_cnt  <= '0;
            timer     <= '0;
            attempts  <= (attempts == 4'hF) ? attempts : attempts + 4'd1;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        // Non-qualifying edges still count but do not restart the timer.
        CHECK: begin
          if (post_edge) begin
            post_cnt <= cnt_next;
          end
          if (check_qual) begin
            state   <= DONE;
            success <= 1'b1;
          end else if (timeout_hit) begin
            state     <= FAIL_RESET;
            reset_req <= 1'b1;
            post_cnt  <= '0;
            timer     <= '0;
            attempts  <= (attempts == 4'hF) ? attempts : attempts + 4'd1;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        // POST edges are ignored while the console is held in reset.
        FAIL_RESET: begin
          if (reset_done) begin
            reset_req <= 1'b0;
            timer     <= '0;
`ifdef ATTEMPT_LIMIT_EN
            if (attempts == MAX_ATTEMPTS) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            timer <= timer + 24'd1;
          end
        end

        DONE: begin
          if (post_edge) begin
            post_cnt <= cnt_next;
          end
        end

`ifdef ATTEMPT_LIMIT_EN
        HALT: begin
          // Everything frozen until rst.
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ATTEMPT_LIMIT_EN
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_post_monitor.sv
// Scoreboard bench for post_monitor. Stimulus tasks toggle post_in and
// push cycle-stamped expectations into a sorted queue; a monitor on the
// falling clock edge pops and compares every entry due at that cycle.
module tb_post_monitor;

  localparam int GAP = 96;   // 1 us at 96 MHz
  localparam int CT  = 300;  // shortened CHECK_TIMEOUT
  localparam int RT  = 40;   // shortened RESET_TICKS

  localparam int S_GLITCH = 0;
  localparam int S_RREQ   = 1;
  localparam int S_SUCC   = 2;
  localparam int S_HALT   = 3;
  localparam int S_ATT    = 4;
  localparam int S_CNT    = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       post_in;
  logic       glitch;
  logic       reset_req;
  logic       success;
  logic       halted;
  logic [3:0] attempts;
  logic [7:0] post_cnt;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];

  post_monitor #(
    .GLITCH_POST  (8'd6),
    .SUCCESS_POST (8'd8),
    .CHECK_TIMEOUT(24'(CT)),
    .RESET_TICKS  (16'(RT)),
    .MAX_ATTEMPTS (4'd2)
  ) dut (
    .clk_96m  (clk),
    .rst      (rst),
    .post_in  (post_in),
    .glitch   (glitch),
    .reset_req(reset_req),
    .success  (success),
    .halted   (halted),
    .attempts (attempts),
    .post_cnt (post_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig_val(input int s);
    case (s)
      S_GLITCH: return int'(glitch);
      S_RREQ:   return int'(reset_req);
      S_SUCC:   return int'(success);
      S_HALT:   return int'(halted);
      S_ATT:    return int'(attempts);
      default:  return int'(post_cnt);
    endcase
  endfunction

  // Keep the scoreboard sorted by cycle so the monitor only inspects the head.
  task automatic push(input int c, input int s, input int v, input string n);
    exp_t e;
    int   idx;
    e.cyc  = c;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic push_range(input int c0, input int c1, input int s, input int v,
                            input string n);
    for (int c = c0; c <= c1; c++) push(c, s, v, n);
  endtask

  task automatic push_all_zero(input int c, input string n);
    for (int s = 0; s < 6; s++) push(c, s, 0, n);
  endtask

  // Monitor: compare every expectation due at or before the current cycle.
  exp_t mon_e;
  int   mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = sig_val(mon_e.sig);
      total++;
      if (mon_act != mon_e.val) begin
        bad++;
        $display("FAIL %s at cycle %0d: got %0d expected %0d",
                 mon_e.name, cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle(output int t);
    @(posedge clk);
    #1;
    post_in = ~post_in;
    t = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_all_zero(cyc, "reset_clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: run did not finish, expected done", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  int t;
  int rise;
  int e_exit;
  int c0;

  initial begin
    rst     = 1'b1;
    post_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_all_zero(cyc, "reset_state");

    // Successful boot: glitch window on toggle 6, closes on 7, success on 8.
    c0 = cyc;
    push_range(c0 + 1, c0 + 8 * GAP + 10, S_RREQ, 0, "no_reset_req");
    for (int k = 1; k <= 8; k++) begin
      toggle(t);
      if (k == 1) push(t + 4, S_CNT, 1, "cnt_first");
      if (k == 6) begin
        push(t + 3, S_GLITCH, 0, "glitch_pre_rise");
        push(t + 4, S_GLITCH, 1, "glitch_rise");
        push(t + 4, S_CNT, 6, "cnt6");
      end
      if (k == 7) begin
        push(t + 3, S_GLITCH, 1, "glitch_pre_fall");
        push(t + 4, S_GLITCH, 0, "glitch_fall");
        push(t + 4, S_CNT, 7, "cnt7");
      end
      if (k == 8) begin
        push(t + 3, S_SUCC, 0, "success_pre");
        push(t + 4, S_SUCC, 1, "success");
        push(t + 4, S_CNT, 8, "cnt8");
        push(t + 4, S_GLITCH, 0, "glitch_done");
      end
      wait_ticks(GAP - 1);
    end

    // DONE keeps counting and saturates at 8'hFF.
    for (int k = 1; k <= 250; k++) begin
      toggle(t);
      if (k == 100) push(t + 4, S_CNT, 108, "cnt_done_count");
      wait_ticks(2);
    end
    push(t + 6, S_CNT, 255, "cnt_saturate");
    push(t + 6, S_SUCC, 1, "success_held");
    push(t + 6, S_GLITCH, 0, "glitch_done_low");
    wait_ticks(10);

    // Failure 1: window opens, no further edge, timeout into FAIL_RESET.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      toggle(t);
      if (k < 6) wait_ticks(GAP - 1);
    end
    push(t + 4, S_GLITCH, 1, "f1_glitch_rise");
    rise = t + 4 + CT;
    push(rise - 1, S_GLITCH, 1, "f1_glitch_held");
    push(rise - 1, S_RREQ, 0, "f1_rreq_pre");
    push(rise - 1, S_ATT, 0, "f1_att_pre");
    push(rise, S_RREQ, 1, "f1_rreq_rise");
    push(rise, S_GLITCH, 0, "f1_glitch_drop");
    push(rise, S_ATT, 1, "f1_attempts");
    push(rise, S_CNT, 0, "f1_cnt_clear");
    push(rise + RT - 1, S_RREQ, 1, "f1_rreq_last");
    push(rise + RT, S_RREQ, 0, "f1_rreq_fall");

    // Edges during FAIL_RESET are ignored and do not stretch the pulse.
    wait_until(rise + 10);
    toggle(t);
    push(t + 4, S_CNT, 0, "fr_cnt_hold");
    push(t + 8, S_CNT, 0, "fr_cnt_hold2");
    push(t + 4, S_RREQ, 1, "fr_rreq_held");

    // Back in IDLE: the next edge restarts the count at 1.
    wait_until(rise + RT + 5);
    toggle(t);
    push(t + 4, S_CNT, 1, "idle_restart");
    push(t + 4, S_GLITCH, 0, "idle_no_glitch");
    push(t + 4, S_RREQ, 0, "idle_rreq_low");
    wait_ticks(GAP - 1);

    // Failure 2: five more toggles bring the count to 6 again.
    for (int k = 2; k <= 6; k++) begin
      toggle(t);
      if (k < 6) wait_ticks(GAP - 1);
    end
    push(t + 4, S_GLITCH, 1, "f2_glitch_rise");
    rise   = t + 4 + CT;
    e_exit = rise + RT;
    push(rise, S_ATT, 2, "f2_attempts");
    push(rise, S_RREQ, 1, "f2_rreq_rise");
    push(e_exit, S_RREQ, 0, "f2_rreq_fall");
`ifdef ATTEMPT_LIMIT_EN
    push(e_exit - 1, S_HALT, 0, "halt_pre");
    push(e_exit, S_HALT, 1, "halted");
    push_range(e_exit, e_exit + 8 * 24 + 12, S_GLITCH, 0, "halt_no_glitch");
    push_range(e_exit, e_exit + 8 * 24 + 12, S_RREQ, 0, "halt_no_rreq");
    wait_until(e_exit + 2);
    for (int k = 1; k <= 8; k++) begin
      toggle(t);
      wait_ticks(23);
    end
    push(cyc + 2, S_CNT, 0, "halt_cnt_frozen");
    push(cyc + 2, S_ATT, 2, "halt_att_frozen");
    push(cyc + 2, S_HALT, 1, "halt_held");
    wait_ticks(4);
`else
    push(e_exit, S_HALT, 0, "no_halt");
    push(e_exit, S_CNT, 0, "f2_cnt_zero");
    wait_until(e_exit + 2);
    toggle(t);
    push(t + 4, S_CNT, 1, "f2_idle_restart");
    push(t + 4, S_HALT, 0, "no_halt_later");
    wait_ticks(8);
`endif

    // rst in the middle of a reset_req pulse clears everything next tick.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      toggle(t);
      if (k < 6) wait_ticks(GAP - 1);
    end
    rise = t + 4 + CT;
    push(rise, S_ATT, 1, "f3_attempts");
    wait_until(rise + 10);
    push(cyc, S_RREQ, 1, "mid_rreq_high");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_all_zero(cyc, "mid_reset_clear");
    push(cyc + 3, S_RREQ, 0, "mid_rreq_stays_low");
    wait_ticks(6);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
